// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and constants for the sequential 128/64 divider.
package div_pkg;

    localparam int DIV_N     = 64;
    localparam int DIV_N2    = 2 * DIV_N;
    localparam int DIV_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_N2-1:0] DIV0_QUOTIENT = {DIV_N2{1'b1}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the divisor, set the quotient bit.
module div_step #(
    parameter int N = 64
) (
    input  logic [N:0]     i_rem,
    input  logic [2*N-1:0] i_q,
    input  logic [N-1:0]   i_divisor,
    output logic [N:0]     o_rem,
    output logic [2*N-1:0] o_q
);

    logic [N+1:0] w_shifted;
    logic         w_fits;

    assign w_shifted = {i_rem, i_q[2*N-1]};
    assign w_fits    = (w_shifted >= {2'b00, i_divisor});
    assign o_rem     = w_fits ? (N+1)'(w_shifted - {2'b00, i_divisor}) : w_shifted[N:0];
    assign o_q       = {i_q[2*N-2:0], w_fits};

endmodule

// File: rtl/seq_div128x64.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_div128x64 #(
    parameter int N     = div_pkg::DIV_N,
    parameter int CNT_W = div_pkg::DIV_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);
    import div_pkg::*;

    state_t         r_state;
    state_t         w_nextState;
    logic [2*N-1:0] r_q;
    logic [N:0]     r_rem;
    logic [N-1:0]   r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic           r_dbz;
    logic [N:0]     w_remNext;
    logic [2*N-1:0] w_qNext;
    logic           w_accept;
    logic           w_divZero;

    assign w_accept  = in_valid && in_ready;
    assign w_divZero = (divisor == '0);

    div_step #(.N(N)) u_step (
        .i_rem     (r_rem),
        .i_q       (r_q),
        .i_divisor (r_divisor),
        .o_rem     (w_remNext),
        .o_q       (w_qNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // CALC spends one extra cycle at counter zero so the result appears 2N+1 edges after acceptance.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_divZero ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_divisor <= divisor;
                        r_dbz     <= w_divZero;
                        r_cnt     <= CNT_W'(2 * N);
                        if (w_divZero) begin
                            r_q   <= {(2*N){1'b1}};
                            r_rem <= {1'b0, dividend[N-1:0]};
                        end else begin
                            r_q   <= dividend;
                            r_rem <= '0;
                        end
                    end
                end
                CALC: begin
                    if (r_cnt != '0) begin
                        r_q   <= w_qNext;
                        r_rem <= w_remNext;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_q;
    assign remainder   = r_rem[N-1:0];
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div128x64.sv
// Self-checking bench for seq_div128x64: directed table, random model checks, backpressure, reset and back-to-back.
module tb_seq_div128x64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] dividend;
    logic [63:0]  divisor;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] quotient;
    logic [63:0]  remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] a;
        logic [63:0]  b;
        logic [127:0] q;
        logic [63:0]  r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    seq_div128x64 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Plain-arithmetic reference: floor division and modulo, with the divide-by-zero convention.
    function automatic void refDivide(input logic [127:0] a, input logic [63:0] b,
                                      output logic [127:0] q, output logic [63:0] r,
                                      output logic dbz, output int lat);
        logic [127:0] r128;
        if (b == 64'd0) begin
            q   = '1;
            r   = a[63:0];
            dbz = 1'b1;
            lat = 0;
        end else begin
            q    = a / {64'd0, b};
            r128 = a % {64'd0, b};
            r    = r128[63:0];
            dbz  = 1'b0;
            lat  = 129;
        end
    endfunction

    task automatic presentOperands(input logic [127:0] a, input logic [63:0] b);
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("inReadyBeforeAccept", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts clock edges after the accepting edge until out_valid is seen.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("outValidTimeout", out_valid, 1);
    endtask

    task automatic applyStimulus(input logic [127:0] a, input logic [63:0] b,
                                 output logic [127:0] q, output logic [63:0] r,
                                 output logic dbz, output int lat);
        presentOperands(a, b);
        waitResult(lat);
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
    endtask

    task automatic finishHandshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("outValidDrop", out_valid, 0);
        checkOutput("inReadyReturn", in_ready, 1);
    endtask

    initial begin
        logic [127:0] gotQ, expQ, a;
        logic [63:0]  gotR, expR, b;
        logic         gotDbz, expDbz;
        int           gotLat, expLat;
        logic [191:0] recon;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{128'h1221, 64'h111, 128'h11, 64'h0, 1'b0, 129};
        vecs[1] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'h1_0000_0000_0000_0001, 64'h0, 1'b0, 129};
        vecs[2] = '{128'h1234_5678, 64'h0, {128{1'b1}}, 64'h1234_5678, 1'b1, 0};
        vecs[3] = '{128'd100, 64'd10, 128'd10, 64'd0, 1'b0, 129};
        vecs[4] = '{128'd1000, 64'd7, 128'd142, 64'd6, 1'b0, 129};
        vecs[5] = '{128'd0, 64'd5, 128'd0, 64'd0, 1'b0, 129};
        vecs[6] = '{128'd5, 64'd9, 128'd0, 64'd5, 1'b0, 129};
        vecs[7] = '{{128{1'b1}}, 64'd1, {128{1'b1}}, 64'd0, 1'b0, 129};

        #2;
        checkOutput("resetInReady", in_ready, 1);
        checkOutput("resetOutValid", out_valid, 0);
        checkOutput("resetQuotient", quotient, 0);
        checkOutput("resetRemainder", remainder, 0);
        checkOutput("resetDivByZero", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, gotQ, gotR, gotDbz, gotLat);
            checkOutput($sformatf("vec%0d.quotient", i), gotQ, vecs[i].q);
            checkOutput($sformatf("vec%0d.remainder", i), gotR, vecs[i].r);
            checkOutput($sformatf("vec%0d.divByZero", i), gotDbz, vecs[i].dbz);
            checkOutput($sformatf("vec%0d.latency", i), gotLat, vecs[i].lat);
            finishHandshake();
        end

        for (int i = 0; i < 8; i++) begin
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i % 2 == 1) a = a >> $urandom_range(0, 100);
            b = (i % 3 == 0) ? {32'd0, $urandom()} : {$urandom(), $urandom()};
            if (i == 5) b = 64'd0;
            refDivide(a, b, expQ, expR, expDbz, expLat);
            applyStimulus(a, b, gotQ, gotR, gotDbz, gotLat);
            checkOutput($sformatf("rand%0d.quotient", i), gotQ, expQ);
            checkOutput($sformatf("rand%0d.remainder", i), gotR, expR);
            checkOutput($sformatf("rand%0d.divByZero", i), gotDbz, expDbz);
            checkOutput($sformatf("rand%0d.latency", i), gotLat, expLat);
            finishHandshake();
        end

        // Backpressure: result must hold for 20 cycles while stray in_valid pulses are ignored.
        applyStimulus(128'd1000, 64'd7, gotQ, gotR, gotDbz, gotLat);
        for (int k = 0; k < 20; k++) begin
            dividend = 128'd999;
            divisor  = 64'd3;
            in_valid = (k % 3 == 0);
            @(posedge clk); #1;
            checkOutput("holdQuotient", quotient, 128'd142);
            checkOutput("holdRemainder", remainder, 64'd6);
            checkOutput("holdOutValid", out_valid, 1);
            checkOutput("holdInReady", in_ready, 0);
        end
        in_valid = 1'b0;
        finishHandshake();
        @(posedge clk); #1;
        checkOutput("noStrayAccept", in_ready, 1);

        // Reset in the middle of a divide abandons it immediately.
        presentOperands(128'hDEAD_BEEF_0123_4567_89AB_CDEF, 64'd3);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetOutValid", out_valid, 0);
        checkOutput("midResetInReady", in_ready, 1);
        checkOutput("midResetQuotient", quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postResetIdle", out_valid, 0);
        applyStimulus(128'd100, 64'd10, gotQ, gotR, gotDbz, gotLat);
        checkOutput("postReset.quotient", gotQ, 128'd10);
        checkOutput("postReset.remainder", gotR, 64'd0);
        checkOutput("postReset.latency", gotLat, 129);
        finishHandshake();

        // Back-to-back: next operands wait during DONE and must be taken right after the handshake.
        out_ready = 1'b1;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        if (b == 64'd0) b = 64'd1;
        presentOperands(a, b);
        for (int i = 0; i < 5; i++) begin
            waitResult(gotLat);
            checkOutput($sformatf("b2b%0d.latency", i), gotLat, 129);
            recon = {64'd0, quotient} * {128'd0, b} + {128'd0, remainder};
            checkOutput($sformatf("b2b%0d.invariant", i), recon, {64'd0, a});
            checkOutput($sformatf("b2b%0d.remLtDiv", i), (remainder < b), 1);
            if (i < 4) begin
                a = {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 64);
                b = (i % 2 == 0) ? {32'd0, $urandom()} : {$urandom(), $urandom()};
                if (b == 64'd0) b = 64'd1;
                dividend = a;
                divisor  = b;
                in_valid = 1'b1;
                @(posedge clk); #1;
                checkOutput($sformatf("b2b%0d.readyAfterHandshake", i), in_ready, 1);
                checkOutput($sformatf("b2b%0d.validDropped", i), out_valid, 0);
                @(posedge clk); #1;
                in_valid = 1'b0;
                checkOutput($sformatf("b2b%0d.acceptedNext", i), in_ready, 0);
            end else begin
                @(posedge clk); #1;
                checkOutput("b2bFinalDrop", out_valid, 0);
            end
        end
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
